// File: rtl/ext_mem_ctrl.sv
// MOVX external data-memory sequencer: drives multiplexed P0/P2, ALE, RD_n, WR_n with fixed phase timing.
// Optional EXT_MEM_WAIT_EN adds a wait_n input that stretches the last strobe cycle.
module ext_mem_ctrl #(
  parameter int unsigned ALE_CYCLES    = 1,
  parameter int unsigned STROBE_CYCLES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic        req_short,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic [7:0]  p2_sfr,
  input  logic [7:0]  p0_in,
`ifdef EXT_MEM_WAIT_EN
  input  logic        wait_n,
`endif
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [7:0]  p2_out,
  output logic [7:0]  p0_out,
  output logic        p0_oe,
  output logic        ale,
  output logic        rd_n,
  output logic        wr_n
);

  // state  | meaning
  // IDLE   | P2 follows the SFR latch, waiting for req
  // ADDR   | ALE high, address on P0/P2
  // LATCH  | ALE low, address held for latch hold time
  // STROBE | RD_n or WR_n low
  // HOLD   | strobes released, done pulse, write data still driven
  typedef enum logic [2:0] {IDLE, ADDR, LATCH, STROBE, HOLD} state_t;

  localparam logic [3:0] ALE_TC = 4'(ALE_CYCLES - 1);
  localparam logic [3:0] STB_TC = 4'(STROBE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        we_q, short_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q, p2_q;
  logic        accept, rd_cap;
  logic        wait_ok;

`ifdef EXT_MEM_WAIT_EN
  assign wait_ok = wait_n;
`else
  assign wait_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata   <= '0;
      we_q    <= 1'b0;
      short_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      p2_q    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= req_we;
        short_q <= req_short;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        p2_q    <= p2_sfr;
      end
      if (rd_cap) rdata <= p0_in;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    rd_cap    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    ale       = 1'b0;
    rd_n      = 1'b1;
    wr_n      = 1'b1;
    p0_oe     = 1'b0;
    p0_out    = '0;
    // SFR value frozen at acceptance so P2 stays stable for the whole access
    p2_out    = short_q ? p2_q : addr_q[15:8];
    case (state)
      IDLE: begin
        busy   = 1'b0;
        p2_out = p2_sfr;
        if (req) begin
          accept    = 1'b1;
          state_nxt = ADDR;
          cnt_nxt   = ALE_TC;
        end
      end
      ADDR: begin
        ale    = 1'b1;
        p0_oe  = 1'b1;
        p0_out = addr_q[7:0];
        if (cnt == 4'd0) state_nxt = LATCH;
        else             cnt_nxt   = cnt - 4'd1;
      end
      LATCH: begin
        p0_oe     = 1'b1;
        p0_out    = addr_q[7:0];
        state_nxt = STROBE;
        cnt_nxt   = STB_TC;
      end
      STROBE: begin
        if (we_q) begin
          wr_n   = 1'b0;
          p0_oe  = 1'b1;
          p0_out = wdata_q;
        end else begin
          rd_n = 1'b0;
        end
        if (cnt == 4'd0) begin
          if (wait_ok) begin
            state_nxt = HOLD;
            rd_cap    = ~we_q;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        done = 1'b1;
        if (we_q) begin
          p0_oe  = 1'b1;
          p0_out = wdata_q;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
